// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter: 32-bit word -> LSB-first mark/space envelope plus gated carrier; `define NEC_REPEAT_EN adds repeat codes.
// All outputs registered, envelope rises the cycle after an accepted start; start is ignored while busy.
module nec_ir_transmitter #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 438,
  parameter int FRAME_UNITS  = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] frame_data,
  input  logic        repeat_req,
  output logic        busy,
  output logic        done,
  output logic        ir_envelope,
  output logic        ir_tx
);
  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam int FW = $clog2(FRAME_UNITS + 1);
  localparam logic [UW-1:0] UNIT_LAST  = UW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CARR_LAST  = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CARR_HIGH  = CW'(CARRIER_HIGH);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_UNITS - 1);

  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
`ifdef NEC_REPEAT_EN
    , REP_MARK, REP_SPACE
`endif
  } state_t;

  state_t          state, state_n;
  logic [UW-1:0]   unit_cnt, unit_n;
  logic [4:0]      seg_units, seg_units_n;
  logic [FW-1:0]   frame_units, frame_units_n;
  logic [4:0]      bit_idx, bit_n;
  logic [31:0]     shreg, shreg_n;
  logic [CW-1:0]   carr_cnt, carr_n;
  logic [4:0]      seg_len;
  logic            unit_end, seg_end, frame_end, env_n, done_n;

`ifndef NEC_REPEAT_EN
  logic unused_repeat_req;
  assign unused_repeat_req = repeat_req;
`endif

  function automatic logic is_mark(input state_t s);
    case (s)
      LEAD_MARK, BIT_MARK, STOP_MARK: return 1'b1;
`ifdef NEC_REPEAT_EN
      REP_MARK: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_n       = state;
    unit_n        = unit_cnt;
    seg_units_n   = seg_units;
    frame_units_n = frame_units;
    bit_n         = bit_idx;
    shreg_n       = shreg;

    case (state)
      LEAD_MARK:  seg_len = 5'd16;
      LEAD_SPACE: seg_len = 5'd8;
      BIT_SPACE:  seg_len = shreg[0] ? 5'd3 : 5'd1;
`ifdef NEC_REPEAT_EN
      REP_MARK:   seg_len = 5'd16;
      REP_SPACE:  seg_len = 5'd4;
`endif
      default:    seg_len = 5'd1;
    endcase

    unit_end  = (unit_cnt == UNIT_LAST);
    seg_end   = unit_end && (seg_units == seg_len - 5'd1);
    // GAP has no fixed length: it stretches until the frame-wide unit count completes.
    frame_end = (state == GAP) && unit_end && (frame_units == FRAME_LAST);

    if (state == IDLE) begin
      if (start) begin
        state_n       = LEAD_MARK;
        shreg_n       = frame_data;
        bit_n         = '0;
        unit_n        = '0;
        seg_units_n   = '0;
        frame_units_n = '0;
      end
    end else if (unit_end) begin
      unit_n        = '0;
      frame_units_n = frame_units + 1'b1;
      seg_units_n   = (state == GAP) ? '0 : seg_units + 1'b1;
      if (frame_end) begin
        frame_units_n = '0;
        state_n       = IDLE;
`ifdef NEC_REPEAT_EN
        if (repeat_req) state_n = REP_MARK;
`endif
      end else if (state != GAP && seg_end) begin
        seg_units_n = '0;
        case (state)
          LEAD_MARK:  state_n = LEAD_SPACE;
          LEAD_SPACE: state_n = BIT_MARK;
          BIT_MARK:   state_n = BIT_SPACE;
          BIT_SPACE: begin
            if (bit_idx == 5'd31) begin
              state_n = STOP_MARK;
            end else begin
              state_n = BIT_MARK;
              bit_n   = bit_idx + 1'b1;
              shreg_n = shreg >> 1;
            end
          end
          STOP_MARK:  state_n = GAP;
`ifdef NEC_REPEAT_EN
          REP_MARK:   state_n = REP_SPACE;
          REP_SPACE:  state_n = STOP_MARK;
`endif
          default:    state_n = IDLE;
        endcase
      end
    end else begin
      unit_n = unit_cnt + 1'b1;
    end

    env_n  = is_mark(state_n);
    done_n = (state_n == GAP) && (unit_n == UNIT_LAST) && (frame_units_n == FRAME_LAST);
    // Restart the carrier on every rising envelope so each mark opens with a high phase.
    if (env_n && !ir_envelope)   carr_n = '0;
    else if (carr_cnt == CARR_LAST) carr_n = '0;
    else                         carr_n = carr_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      unit_cnt    <= '0;
      seg_units   <= '0;
      frame_units <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      carr_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ir_envelope <= 1'b0;
      ir_tx       <= 1'b0;
    end else begin
      state       <= state_n;
      unit_cnt    <= unit_n;
      seg_units   <= seg_units_n;
      frame_units <= frame_units_n;
      bit_idx     <= bit_n;
      shreg       <= shreg_n;
      carr_cnt    <= carr_n;
      busy        <= (state_n != IDLE);
      done        <= done_n;
      ir_envelope <= env_n;
      ir_tx       <= env_n && (carr_n < CARR_HIGH);
    end
  end
endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Directed bench for nec_ir_transmitter with shortened units; each frame is compared cycle by cycle against a
// reference envelope built from the NEC frame layout, and the sent word is decoded back from space lengths.
module tb_nec_ir_transmitter;
  localparam int UC        = 10;
  localparam int DIV       = 3;
  localparam int HIGH      = 1;
  localparam int FU        = 192;
  localparam int FRAME_CYC = FU * UC;

  logic        clk = 1'b0;
  logic        reset, start, repeat_req;
  logic [31:0] frame_data;
  logic        busy, done, ir_envelope, ir_tx;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_env [FRAME_CYC];

  always #5 clk = ~clk;

  nec_ir_transmitter #(
    .UNIT_CYCLES(UC), .CARRIER_DIV(DIV), .CARRIER_HIGH(HIGH), .FRAME_UNITS(FU)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_data(frame_data), .repeat_req(repeat_req),
    .busy(busy), .done(done), .ir_envelope(ir_envelope), .ir_tx(ir_tx)
  );

  task automatic build_exp(input logic [31:0] w, input bit rep);
    int k = 0;
    for (int i = 0; i < FRAME_CYC; i++) exp_env[i] = 1'b0;
    for (int i = 0; i < 16 * UC; i++) begin exp_env[k] = 1'b1; k++; end
    if (rep) begin
      k += 4 * UC;
    end else begin
      k += 8 * UC;
      for (int b = 0; b < 32; b++) begin
        for (int i = 0; i < UC; i++) begin exp_env[k] = 1'b1; k++; end
        k += (w[b] ? 3 : 1) * UC;
      end
    end
    for (int i = 0; i < UC; i++) begin exp_env[k] = 1'b1; k++; end
  endtask

  // Called at the negedge right after the accepting edge; returns at the negedge after the frame.
  task automatic observe_frame(input string tag, input logic [31:0] w, input bit rep,
                               input int poke_at, input logic [31:0] poke_data);
    int env_err = 0, tx_err = 0, busy_err = 0, done_cnt = 0, done_at = -1, marks = 0;
    int pos = 0, sp_len = 0, nsp = 0, exp_marks;
    logic prev_e = 1'b1;
    logic exp_tx;
    logic [31:0] dec = '0;
    build_exp(w, rep);
    exp_marks = rep ? 17 * UC : 49 * UC;
    for (int n = 1; n <= FRAME_CYC; n++) begin
      int k;
      k = n - 1;
      if (exp_env[k]) begin
        pos    = (k == 0 || !exp_env[k-1]) ? 0 : pos + 1;
        exp_tx = ((pos % DIV) < HIGH);
      end else begin
        exp_tx = 1'b0;
      end
      if (ir_envelope !== exp_env[k]) env_err++;
      if (ir_tx !== exp_tx) tx_err++;
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin done_cnt++; done_at = n; end
      if (ir_envelope === 1'b1) begin
        marks++;
        if (!prev_e) begin
          if (nsp >= 1 && nsp <= 32) dec[nsp-1] = (sp_len > 2 * UC);
          if (sp_len > 0) nsp++;
          sp_len = 0;
        end
      end else begin
        sp_len++;
      end
      prev_e = ir_envelope;
      if (n == poke_at) begin start = 1'b1; frame_data = poke_data; end
      if (n == poke_at + 1) start = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (env_err !== 0) begin n_bad++; $display("FAIL %s envelope: %0d cycles differ, want 0", tag, env_err); end
    n_cmp++; if (tx_err !== 0) begin n_bad++; $display("FAIL %s ir_tx: %0d cycles differ, want 0", tag, tx_err); end
    n_cmp++; if (busy_err !== 0) begin n_bad++; $display("FAIL %s busy: low on %0d cycles, want 0", tag, busy_err); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL %s done count: got %0d want 1", tag, done_cnt); end
    n_cmp++; if (done_at !== FRAME_CYC) begin n_bad++; $display("FAIL %s done cycle: got %0d want %0d", tag, done_at, FRAME_CYC); end
    n_cmp++; if (marks !== exp_marks) begin n_bad++; $display("FAIL %s mark cycles: got %0d want %0d", tag, marks, exp_marks); end
    if (!rep) begin
      n_cmp++; if (dec !== w) begin n_bad++; $display("FAIL %s decoded word: got %h want %h", tag, dec, w); end
    end
  endtask

  task automatic send(input logic [31:0] w);
    start = 1'b1; frame_data = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; frame_data = 32'hFE01_0000; repeat_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", done); end
    n_cmp++; if (ir_envelope !== 1'b0) begin n_bad++; $display("FAIL reset envelope: got %b want 0", ir_envelope); end
    n_cmp++; if (ir_tx !== 1'b0) begin n_bad++; $display("FAIL reset ir_tx: got %b want 0", ir_tx); end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_frame;
    send(32'hFE01_0000);
    observe_frame("button1", 32'hFE01_0000, 1'b0, -1, '0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL button1 post busy: got %b want 0", busy); end
  endtask

  task automatic test_word_patterns;
    send(32'hFD02_00FF);
    observe_frame("button2", 32'hFD02_00FF, 1'b0, -1, '0);
    @(negedge clk);
    send(32'h0000_0000);
    observe_frame("all_zero", 32'h0000_0000, 1'b0, -1, '0);
    @(negedge clk);
    send(32'hFFFF_FFFF);
    observe_frame("all_one", 32'hFFFF_FFFF, 1'b0, -1, '0);
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    send(32'h1234_A55A);
    observe_frame("restart_ignored", 32'h1234_A55A, 1'b0, 500, 32'h0F0F_F0F0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL restart_ignored post busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_midframe;
    send(32'hFE01_0000);
    repeat (699) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midframe busy: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort busy: got %b want 0", busy); end
    n_cmp++; if (ir_envelope !== 1'b0) begin n_bad++; $display("FAIL abort envelope: got %b want 0", ir_envelope); end
    n_cmp++; if (ir_tx !== 1'b0) begin n_bad++; $display("FAIL abort ir_tx: got %b want 0", ir_tx); end
    repeat (5) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort stays idle: busy %b want 0", busy); end
    send(32'hC3A5_5A3C);
    observe_frame("after_abort", 32'hC3A5_5A3C, 1'b0, -1, '0);
  endtask

  task automatic test_start_on_done;
    send(32'h0001_8000);
    observe_frame("start_on_done", 32'h0001_8000, 1'b0, FRAME_CYC, 32'h8000_0001);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_on_done idle: busy %b want 0", busy); end
    @(negedge clk);
    start = 1'b0;
    observe_frame("accepted_after_done", 32'h8000_0001, 1'b0, -1, '0);
  endtask

  task automatic test_back_to_back;
    start = 1'b1; frame_data = 32'hAAAA_5555;
    @(negedge clk);
    observe_frame("b2b_first", 32'hAAAA_5555, 1'b0, -1, '0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b gap busy: got %b want 0", busy); end
    n_cmp++; if (ir_envelope !== 1'b0) begin n_bad++; $display("FAIL b2b gap envelope: got %b want 0", ir_envelope); end
    frame_data = 32'h7E81_00FF;
    @(negedge clk);
    start = 1'b0;
    observe_frame("b2b_second", 32'h7E81_00FF, 1'b0, -1, '0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b end busy: got %b want 0", busy); end
  endtask

  task automatic test_repeat;
    repeat_req = 1'b1;
    send(32'hFE01_0000);
`ifdef NEC_REPEAT_EN
    observe_frame("rep_data", 32'hFE01_0000, 1'b0, -1, '0);
    observe_frame("rep_1", 32'hFE01_0000, 1'b1, 100, 32'h0000_0000);
    repeat_req = 1'b0;
    observe_frame("rep_2", 32'hFE01_0000, 1'b1, -1, '0);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL repeat end busy: got %b want 0", busy); end
`else
    observe_frame("rep_disabled", 32'hFE01_0000, 1'b0, -1, '0);
    repeat_req = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL repeat disabled busy: got %b want 0", busy); end
    n_cmp++; if (ir_envelope !== 1'b0) begin n_bad++; $display("FAIL repeat disabled envelope: got %b want 0", ir_envelope); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_word_patterns();
    test_start_ignored();
    test_reset_midframe();
    test_start_on_done();
    test_back_to_back();
    test_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
